// File: rtl/id_inst_queue_ctrl_pkg.sv
// Shared widths and the opcode pre-decoder for the ID-stage instruction queue.
//   ID_QUEUE_DEPTH       default number of queue entries (power of two, >= 2)
//   INST_WIDTH           instruction word width
//   OD_TO_ISP_BUS_WIDTH  width of the decoded bus handed to issue
//   op_decode()          {op31_26 1-hot[64], op25_22 1-hot[16], op21_20 1-hot[4],
//                         op19_15 1-hot[32], inst[32]}
package id_inst_queue_ctrl_pkg;

  localparam int ID_QUEUE_DEPTH      = 2;
  localparam int INST_WIDTH          = 32;
  localparam int OD_TO_ISP_BUS_WIDTH = 148;

  function automatic logic [OD_TO_ISP_BUS_WIDTH-1:0] op_decode(input logic [INST_WIDTH-1:0] inst);
    logic [63:0] d31_26;
    logic [15:0] d25_22;
    logic [3:0]  d21_20;
    logic [31:0] d19_15;
    d31_26 = '0;
    d25_22 = '0;
    d21_20 = '0;
    d19_15 = '0;
    d31_26[inst[31:26]] = 1'b1;
    d25_22[inst[25:22]] = 1'b1;
    d21_20[inst[21:20]] = 1'b1;
    d19_15[inst[19:15]] = 1'b1;
    return {d31_26, d25_22, d21_20, d19_15, inst};
  endfunction

endpackage

// File: rtl/id_inst_fifo.sv
// In-order DEPTH x W storage for fetched {pc,inst} beats.
//   clk, rst_n   clock, async active-low reset
//   push/wr_data write one entry at the tail
//   pop          discard the head entry
//   flush        synchronous clear of count and pointers (wins over push/pop)
//   head         data at the head (valid when !empty)
//   full, empty  occupancy flags
module id_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/id_inst_queue_ctrl.sv
// Decode-stage sequencer between fetch (IF) and issue (ISP).
//   clk, rst_n                         clock, async active-low reset
//   if_to_id_valid/pc/inst, id_allowin IF-side handshake
//   id_to_isp_valid/pc/bus, isp_allowin ISP-side handshake (registered outputs)
//   flush                              discard everything held, block this cycle's accept
//   stall_cnt                          saturating count of valid & !isp_allowin cycles
// Handshake: a beat transfers on a cycle where valid and allowin are both high at the
// clock edge; valid does not depend on allowin from the same side, and id_allowin
// depends only on registered queue occupancy and flush.
module id_inst_queue_ctrl
  import id_inst_queue_ctrl_pkg::*;
#(
  parameter int DEPTH  = ID_QUEUE_DEPTH,
  parameter int PC_W   = 32,
  parameter int INST_W = INST_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           if_to_id_valid,
  input  logic [PC_W-1:0]                if_to_id_pc,
  input  logic [INST_W-1:0]              if_to_id_inst,
  output logic                           id_allowin,
  output logic                           id_to_isp_valid,
  output logic [PC_W-1:0]                id_to_isp_pc,
  output logic [OD_TO_ISP_BUS_WIDTH-1:0] id_to_isp_bus,
  input  logic                           isp_allowin,
  input  logic                           flush,
  output logic [31:0]                    stall_cnt
);

  logic                   q_full;
  logic                   q_empty;
  logic [PC_W+INST_W-1:0] q_head;
  logic                   in_fire;
  logic                   out_fire;
  logic                   ld;
  logic                   bypass;
  logic                   q_push;
  logic                   q_pop;
  logic                   src_valid;
  logic [PC_W+INST_W-1:0] src;
  logic [OD_TO_ISP_BUS_WIDTH-1:0] src_bus;

  // Full blocks accept even if a pop happens this cycle; reopens the cycle after.
  assign id_allowin = !q_full && !flush;
  assign in_fire    = if_to_id_valid && id_allowin;
  assign out_fire   = id_to_isp_valid && isp_allowin;
  assign ld         = !id_to_isp_valid || out_fire;

  // Bypass only when the queue is empty so a new beat never overtakes a queued one.
  assign bypass    = ld && q_empty && in_fire;
  assign q_push    = in_fire && !bypass;
  assign q_pop     = ld && !q_empty;
  assign src_valid = !q_empty || in_fire;
  assign src       = q_empty ? {if_to_id_pc, if_to_id_inst} : q_head;
  assign src_bus   = op_decode(src[INST_W-1:0]);

  id_inst_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (q_push),
    .pop     (q_pop),
    .flush   (flush),
    .wr_data ({if_to_id_pc, if_to_id_inst}),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  // ID pipeline register: holds steady while valid && !isp_allowin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_to_isp_valid <= 1'b0;
      id_to_isp_pc    <= '0;
      id_to_isp_bus   <= '0;
    end else if (flush) begin
      id_to_isp_valid <= 1'b0;
    end else if (ld) begin
      id_to_isp_valid <= src_valid;
      if (src_valid) begin
        id_to_isp_pc  <= src[PC_W+INST_W-1:INST_W];
        id_to_isp_bus <= src_bus;
      end
    end
  end

  // Back-pressure counter; survives flush, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_to_isp_valid && !isp_allowin && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_inst_queue_ctrl.sv
// Self-checking bench for id_inst_queue_ctrl: directed scenarios followed by random
// traffic, with a program-order reference queue checked by a negedge monitor.
module tb_id_inst_queue_ctrl;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int BUS_W = 148;
  localparam int ENT_W = PC_W + BUS_W;

  logic             clk;
  logic             rst_n;
  logic             if_to_id_valid;
  logic [PC_W-1:0]  if_to_id_pc;
  logic [31:0]      if_to_id_inst;
  logic             id_allowin;
  logic             id_to_isp_valid;
  logic [PC_W-1:0]  id_to_isp_pc;
  logic [BUS_W-1:0] id_to_isp_bus;
  logic             isp_allowin;
  logic             flush;
  logic [31:0]      stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [ENT_W-1:0] exp_q[$];
  logic [31:0]      stall_m;
  logic             sat_override = 1'b0;
  logic [31:0]      sat_val;
  logic             prev_hold;
  logic [ENT_W-1:0] prev_out;

  id_inst_queue_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_pc     (if_to_id_pc),
    .if_to_id_inst   (if_to_id_inst),
    .id_allowin      (id_allowin),
    .id_to_isp_valid (id_to_isp_valid),
    .id_to_isp_pc    (id_to_isp_pc),
    .id_to_isp_bus   (id_to_isp_bus),
    .isp_allowin     (isp_allowin),
    .flush           (flush),
    .stall_cnt       (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference decode ----------------
  function automatic logic [BUS_W-1:0] ref_decode(input logic [31:0] inst);
    logic [63:0] a;
    logic [15:0] b;
    logic [3:0]  c;
    logic [31:0] d;
    a = 64'd1 << inst[31:26];
    b = 16'd1 << inst[25:22];
    c = 4'd1  << inst[21:20];
    d = 32'd1 << inst[19:15];
    return {a, b, c, d, inst};
  endfunction

  task automatic chk(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [31:0] p, input logic [31:0] i,
                       input logic ia, input logic fl, output logic acc);
    if_to_id_valid = v;
    if_to_id_pc    = p;
    if_to_id_inst  = i;
    isp_allowin    = ia;
    flush          = fl;
    #1;
    acc = v & id_allowin;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ia);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 32'h0, ia, 1'b0, acc);
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] i, input logic ia);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, p, i, ia, 1'b0, acc);
    chk("send_accepted", ENT_W'(acc), ENT_W'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},  ENT_W'(id_to_isp_valid), '0);
    chk({tag, "_allowin"}, ENT_W'(id_allowin), ENT_W'(1));
    chk({tag, "_pc"},     ENT_W'(id_to_isp_pc), '0);
    chk({tag, "_bus"},    ENT_W'(id_to_isp_bus), '0);
    chk({tag, "_stall"},  ENT_W'(stall_cnt), '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic exp_valid, exp_allowin, in_fire, out_fire;
    logic [ENT_W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      stall_m   = '0;
      prev_hold = 1'b0;
    end else begin
      if (sat_override) begin
        stall_m      = sat_val;
        sat_override = 1'b0;
      end
      // Everything held lives in the ID register first, the rest in the queue.
      exp_valid   = (exp_q.size() > 0);
      exp_allowin = (exp_q.size() <= DEPTH) && !flush;
      chk("valid", ENT_W'(id_to_isp_valid), ENT_W'(exp_valid));
      chk("allowin", ENT_W'(id_allowin), ENT_W'(exp_allowin));
      chk("stall_cnt", ENT_W'(stall_cnt), ENT_W'(stall_m));
      if (prev_hold) chk("hold_stable", {id_to_isp_pc, id_to_isp_bus}, prev_out);
      out_fire = exp_valid && isp_allowin;
      in_fire  = if_to_id_valid && exp_allowin;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", ENT_W'(1), ENT_W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_entry", {id_to_isp_pc, id_to_isp_bus}, e);
        end
      end
      if (flush) exp_q.delete();
      else if (in_fire) exp_q.push_back({if_to_id_pc, ref_decode(if_to_id_inst)});
      if (exp_valid && !isp_allowin && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
      prev_hold = exp_valid && !isp_allowin && !flush;
      prev_out  = {id_to_isp_pc, id_to_isp_bus};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    logic [31:0] pc;
    rst_n = 1'b0;
    if_to_id_valid = 1'b0;
    if_to_id_pc = '0;
    if_to_id_inst = '0;
    isp_allowin = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Bypass: one-cycle IF->ISP latency
    cycle(1'b1, 32'h1c00_0000, 32'h0280_0421, 1'b1, 1'b0, acc);
    chk("bypass_valid", ENT_W'(id_to_isp_valid), ENT_W'(1));
    chk("bypass_inst", ENT_W'(id_to_isp_bus[31:0]), ENT_W'(32'h0280_0421));
    chk("bypass_op0", ENT_W'(id_to_isp_bus[84]), ENT_W'(1));
    idle(2, 1'b1);

    // Fill under back-pressure, stall, then drain in order
    send(32'h1c00_1000, $urandom, 1'b0);
    send(32'h1c00_1004, $urandom, 1'b0);
    send(32'h1c00_1008, $urandom, 1'b0);
    #1;
    chk("full_allowin", ENT_W'(id_allowin), ENT_W'(0));
    idle(5, 1'b0);
    send(32'h1c00_100c, $urandom, 1'b1);
    idle(6, 1'b1);

    // Flush with two queued plus a valid output
    send(32'h1c00_2000, $urandom, 1'b0);
    send(32'h1c00_2004, $urandom, 1'b0);
    send(32'h1c00_2008, $urandom, 1'b0);
    if_to_id_valid = 1'b1;
    if_to_id_pc    = 32'h1c00_200c;
    isp_allowin    = 1'b0;
    flush          = 1'b1;
    #1;
    chk("flush_allowin", ENT_W'(id_allowin), ENT_W'(0));
    @(posedge clk);
    #1;
    chk("flush_valid", ENT_W'(id_to_isp_valid), ENT_W'(0));
    send(32'h1c00_0100, $urandom, 1'b1);
    idle(3, 1'b1);

    // Stall counter saturation
    send(32'h1c00_3000, $urandom, 1'b0);
    #1;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    sat_val = 32'hFFFF_FFFE;
    sat_override = 1'b1;
    idle(3, 1'b0);
    chk("stall_saturated", ENT_W'(stall_cnt), ENT_W'(32'hFFFF_FFFF));
    idle(2, 1'b1);

    // Async reset mid-stream
    send(32'h1c00_4000, $urandom, 1'b0);
    send(32'h1c00_4004, $urandom, 1'b0);
    if_to_id_valid = 1'b1;
    if_to_id_pc    = 32'h1c00_4008;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    idle(2, 1'b1);
    rst_n = 1'b1;
    send(32'h1c00_5000, $urandom, 1'b1);
    idle(2, 1'b1);

    // Random traffic
    pc = 32'h1c01_0000;
    for (int n = 0; n < 2000; n++) begin
      logic v, ia, fl;
      v  = ($urandom_range(0, 3) != 0);
      ia = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 40) == 0);
      cycle(v, pc, $urandom, ia, fl, acc);
      if (acc) pc = pc + 32'd4;
    end
    idle(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
